alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 123 ++++++++++++
 tb/tb_alu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 16-lane x 32-bit SIMD multiply/add unit with a registered result and a two-state control FSM.
//
// Ports:
//   clk    - sole clock; all state updates on the rising edge
//   rst_n  - asynchronous active-low reset; clears the results and returns the FSM to IDLE
//   start  - arm/clear command; clears A3/A4 and enters ACTIVE (highest priority)
//   mul    - lane-wise multiply request (wins over add)
//   add    - lane-wise add request
//   A1, A2 - 512-bit operand vectors, lane k = bits [32k+31:32k]
//   A3     - registered low-result vector (product low word or sum low word)
//   A4     - registered high-result vector (product high word or extended carry/sign)
//
// Configuration:
//   ALU_SIGNED_EN - when defined, lanes are two's-complement: the product is signed and the
//                   add high word is the sign-extended bit 32 of the 33-bit signed sum.
//                   When undefined, lanes are unsigned and the add high word is the carry.
//
// Operations take effect only in ACTIVE; after reset a start command is needed first.
// Latency is one clock and a new operation is accepted every cycle.

module alu (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mul,
  input  logic         add,
  input  logic [511:0] A1,
  input  logic [511:0] A2,
  output logic [511:0] A3,
  output logic [511:0] A4
);

  localparam int unsigned Lanes = 16;
  localparam int unsigned LaneW = 32;

  typedef enum logic {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [511:0] a3_q, a3_d;
  logic [511:0] a4_q, a4_d;

  // Per-lane combinational results, packed in the same lane layout as the ports.
  logic [511:0] mul_lo, mul_hi;
  logic [511:0] add_lo, add_hi;

  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    logic [LaneW-1:0]   op_a, op_b;
    logic [2*LaneW-1:0] op_a_wide, op_b_wide, prod;
    logic [LaneW:0]     sum;

    assign op_a = A1[LaneW*k +: LaneW];
    assign op_b = A2[LaneW*k +: LaneW];

`ifdef ALU_SIGNED_EN
    // Sign-extending to full width makes the truncated unsigned product equal the signed one.
    assign op_a_wide = {{LaneW{op_a[LaneW-1]}}, op_a};
    assign op_b_wide = {{LaneW{op_b[LaneW-1]}}, op_b};
    assign sum       = {op_a[LaneW-1], op_a} + {op_b[LaneW-1], op_b};
    assign add_hi[LaneW*k +: LaneW] = {LaneW{sum[LaneW]}};
`else
    assign op_a_wide = {{LaneW{1'b0}}, op_a};
    assign op_b_wide = {{LaneW{1'b0}}, op_b};
    assign sum       = {1'b0, op_a} + {1'b0, op_b};
    assign add_hi[LaneW*k +: LaneW] = {{(LaneW-1){1'b0}}, sum[LaneW]};
`endif

    assign prod = op_a_wide * op_b_wide;

    assign mul_lo[LaneW*k +: LaneW] = prod[LaneW-1:0];
    assign mul_hi[LaneW*k +: LaneW] = prod[2*LaneW-1:LaneW];
    assign add_lo[LaneW*k +: LaneW] = sum[LaneW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ACTIVE persists until reset.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StActive;
    end
  end

  // Result next-state: start clears, then mul over add, otherwise hold.
  always_comb begin
    a3_d = a3_q;
    a4_d = a4_q;
    if (start) begin
      a3_d = '0;
      a4_d = '0;
    end else if (state_q == StActive) begin
      if (mul) begin
        a3_d = mul_lo;
        a4_d = mul_hi;
      end else if (add) begin
        a3_d = add_lo;
        a4_d = add_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a3_q <= '0;
      a4_q <= '0;
    end else begin
      a3_q <= a3_d;
      a4_q <= a4_d;
    end
  end

  assign A3 = a3_q;
  assign A4 = a4_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu block. Expected values are hand-computed constants.
// Honours ALU_SIGNED_EN so the same bench covers both builds.

module tb_alu;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mul;
  logic         add;
  logic [511:0] A1;
  logic [511:0] A2;
  logic [511:0] A3;
  logic [511:0] A4;

  int checks;
  int errors;

  logic [511:0] top_bit;
  logic [511:0] exp3;
  logic [511:0] exp4;

  alu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mul   (mul),
    .add   (add),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .A4    (A4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 16; k++) begin
      A1[32*k +: 32] = $urandom;
      A2[32*k +: 32] = $urandom;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    top_bit = '0;
    top_bit[511] = 1'b1;

    // Reset with live-looking stimulus: outputs must be zero.
    rst_n = 1'b0;
    start = 1'b0;
    mul   = 1'b1;
    add   = 1'b0;
    rand_ops();
    #2;
    check("reset_a3", A3, '0);
    check("reset_a4", A4, '0);
    tick();
    tick();
    check("reset_held_a3", A3, '0);
    check("reset_held_a4", A4, '0);

    // Release without start: IDLE ignores requests.
    rst_n = 1'b1;
    tick();
    rand_ops();
    add = 1'b1;
    tick();
    check("idle_mul_a3", A3, '0);
    check("idle_mul_a4", A4, '0);

    // Arm.
    start = 1'b1;
    mul   = 1'b1;
    add   = 1'b0;
    tick();
    check("start_a3", A3, '0);
    check("start_a4", A4, '0);
    start = 1'b0;

    // Top-lane multiply: 2^31 * 2^31 = 2^62 in either signedness.
    A1   = top_bit;
    A2   = top_bit;
    mul  = 1'b1;
    tick();
    exp4 = '0;
    exp4[511:480] = 32'h4000_0000;
    check("top_mul_a3", A3, '0);
    check("top_mul_a4", A4, exp4);

    // Top-lane add.
    mul  = 1'b0;
    add  = 1'b1;
    tick();
    exp4 = '0;
`ifdef ALU_SIGNED_EN
    exp4[511:480] = 32'hFFFF_FFFF;
`else
    exp4[511:480] = 32'h0000_0001;
`endif
    check("top_add_a3", A3, '0);
    check("top_add_a4", A4, exp4);

    // No request in ACTIVE: hold.
    add = 1'b0;
    rand_ops();
    tick();
    check("hold_a3", A3, '0);
    check("hold_a4", A4, exp4);

    // Priority: mul wins; lane 0 = 3 * 5.
    A1 = '0;
    A2 = '0;
    A1[31:0] = 32'd3;
    A2[31:0] = 32'd5;
    mul = 1'b1;
    add = 1'b1;
    tick();
    exp3 = '0;
    exp3[31:0] = 32'd15;
    check("prio_a3", A3, exp3);
    check("prio_a4", A4, '0);

    // Lane-0 add carry must not leak into lane 1.
    A1[31:0] = 32'hFFFF_FFFF;
    A2[31:0] = 32'h0000_0001;
    mul = 1'b0;
    tick();
    exp4 = '0;
`ifndef ALU_SIGNED_EN
    exp4[31:0] = 32'h0000_0001;
`endif
    check("carry_a3", A3, '0);
    check("carry_a4", A4, exp4);

    // Mixed lanes multiply: lane 2 = 0x10000 * 0x10000 = 2^32, lane 7 = 7 * 9 = 63.
    A1 = '0;
    A2 = '0;
    A1[95:64]  = 32'h0001_0000;
    A2[95:64]  = 32'h0001_0000;
    A1[255:224] = 32'd7;
    A2[255:224] = 32'd9;
    mul = 1'b1;
    add = 1'b0;
    tick();
    exp3 = '0;
    exp3[255:224] = 32'd63;
    exp4 = '0;
    exp4[95:64] = 32'h0000_0001;
    check("lanes_mul_a3", A3, exp3);
    check("lanes_mul_a4", A4, exp4);

    // Re-asserted start with mul clears again.
    start = 1'b1;
    tick();
    check("restart_a3", A3, '0);
    check("restart_a4", A4, '0);
    start = 1'b0;

    // All-lanes max multiply.
    A1 = '1;
    A2 = '1;
    tick();
`ifdef ALU_SIGNED_EN
    exp3 = {16{32'h0000_0001}};
    exp4 = '0;
`else
    exp3 = {16{32'h0000_0001}};
    exp4 = {16{32'hFFFF_FFFE}};
`endif
    check("max_mul_a3", A3, exp3);
    check("max_mul_a4", A4, exp4);

    // Asynchronous reset mid-cycle clears immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a3", A3, '0);
    check("async_rst_a4", A4, '0);

    // After release, start is needed again.
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_a3", A3, '0);
    check("post_rst_a4", A4, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
